axi_pack_ssr_read_issuer: RTL and testbench

AXI_PACK_SSR_READ_ISSUER -- requirements
Module: axi_pack_ssr_read_issuer

---
 rtl/axi_pack_pkg.sv | 76 +++++++
 rtl/axi_pack_ssr_read_issuer.sv | 144 ++++++++++++++
 tb/tb_axi_pack_ssr_read_issuer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pack_pkg.sv
// Shared SSR AXI types and constants for the axi_pack datapath.
package axi_pack_pkg;

  localparam int unsigned SsrAddrWidth = 32;
  localparam int unsigned SsrDataWidth = 32;
  localparam int unsigned SsrIdWidth   = 2;

  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef struct packed {
    logic       indirect_enable;
    logic [3:0] elem_tag;
  } ssr_user_t;

  typedef struct packed {
    logic [SsrIdWidth-1:0]   id;
    logic [SsrAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
    logic                    lock;
    logic [3:0]              cache;
    logic [2:0]              prot;
    logic [3:0]              qos;
    logic [3:0]              region;
    ssr_user_t               user;
  } ssr_ax_chan_t;

  typedef struct packed {
    logic [SsrDataWidth-1:0]   data;
    logic [SsrDataWidth/8-1:0] strb;
    logic                      last;
  } ssr_w_chan_t;

  typedef struct packed {
    logic [SsrIdWidth-1:0] id;
    logic [1:0]            resp;
  } ssr_b_chan_t;

  typedef struct packed {
    logic [SsrIdWidth-1:0]   id;
    logic [SsrDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
    ssr_user_t               user;
  } ssr_r_chan_t;

  typedef struct packed {
    ssr_ax_chan_t aw;
    logic         aw_valid;
    ssr_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    ssr_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } ssr_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    ssr_b_chan_t b;
    logic        r_valid;
    ssr_r_chan_t r;
  } ssr_rsp_t;

  // AXI size encoding for a beat of the given byte count.
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/axi_pack_ssr_read_issuer.sv
// Splits a strided element descriptor into AR bursts and streams R data back out.
module axi_pack_ssr_read_issuer
  import axi_pack_pkg::*;
#(
  parameter int unsigned AddrWidth          = 32,
  parameter int unsigned DataWidth          = 32,
  parameter int unsigned AxiIdWidth         = 2,
  parameter int unsigned MaxBurstLen        = 256,
  parameter int unsigned NumOutstandingRead = 2,
  parameter type         axi_ssr_req_t      = ssr_req_t,
  parameter type         axi_ssr_rsp_t      = ssr_rsp_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 desc_valid_i,
  output logic                 desc_ready_o,
  input  logic [AddrWidth-1:0] desc_addr_i,
  input  logic [31:0]          desc_num_i,
  input  logic [AddrWidth-1:0] desc_stride_i,
  input  ssr_user_t            desc_user_i,
  output axi_ssr_req_t         axi_ssr_req_o,
  input  axi_ssr_rsp_t         axi_ssr_rsp_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 data_ready_i,
  output logic                 data_last_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int unsigned OutsWidth = $clog2(NumOutstandingRead + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [AddrWidth-1:0] r_base;
  logic [AddrWidth-1:0] r_stride;
  ssr_user_t            r_user;
  logic [31:0]          r_remaining;
  logic [31:0]          r_issued;
  logic [OutsWidth-1:0] r_outstanding;
  logic                 r_err;

  logic                 w_desc_hs;
  logic                 w_ar_valid;
  logic                 w_ar_hs;
  logic                 w_r_hs;
  logic                 w_r_last_hs;
  logic [31:0]          w_beats;
  logic [AddrWidth-1:0] w_ar_addr;
  logic                 w_unused;

  assign w_desc_hs   = desc_valid_i && (r_state == IDLE);
  assign w_ar_valid  = (r_state == ISSUE) &&
                       (r_outstanding < OutsWidth'(NumOutstandingRead));
  assign w_ar_hs     = w_ar_valid && axi_ssr_rsp_i.ar_ready;
  assign w_r_hs      = axi_ssr_rsp_i.r_valid && data_ready_i;
  assign w_r_last_hs = w_r_hs && axi_ssr_rsp_i.r.last;
  assign w_beats     = (r_remaining > 32'(MaxBurstLen)) ? 32'(MaxBurstLen) : r_remaining;
  assign w_ar_addr   = r_base + AddrWidth'(r_issued) * r_stride;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: accept, issue until every beat is requested, then wait for all bursts to return.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (desc_valid_i) w_state_nxt = (desc_num_i == 32'd0) ? DRAIN : ISSUE;
      ISSUE:   if (w_ar_hs && (r_remaining == w_beats)) w_state_nxt = DRAIN;
      DRAIN:   if (r_outstanding == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Descriptor latch, issue progress and sticky read error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_base      <= '0;
      r_stride    <= '0;
      r_user      <= '0;
      r_remaining <= '0;
      r_issued    <= '0;
      r_err       <= 1'b0;
    end else if (w_desc_hs) begin
      r_base      <= desc_addr_i;
      r_stride    <= desc_stride_i;
      r_user      <= desc_user_i;
      r_remaining <= desc_num_i;
      r_issued    <= '0;
      r_err       <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_issued    <= r_issued + w_beats;
        r_remaining <= r_remaining - w_beats;
      end
      if (w_r_hs && axi_ssr_rsp_i.r.resp[1]) r_err <= 1'b1;
    end
  end

  // In-flight burst count: up on AR accept, down on the closing R beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= '0;
    end else if (w_ar_hs && !w_r_last_hs) begin
      r_outstanding <= r_outstanding + OutsWidth'(1);
    end else if (!w_ar_hs && w_r_last_hs && (r_outstanding != '0)) begin
      r_outstanding <= r_outstanding - OutsWidth'(1);
    end
  end

  // AXI request: read-only master, AR payload derived from held registers so it stays stable.
  always_comb begin
    axi_ssr_req_o          = '0;
    axi_ssr_req_o.b_ready  = 1'b1;
    axi_ssr_req_o.ar_valid = w_ar_valid;
    axi_ssr_req_o.ar.id    = SsrIdWidth'({AxiIdWidth{1'b0}});
    axi_ssr_req_o.ar.addr  = SsrAddrWidth'(w_ar_addr);
    axi_ssr_req_o.ar.len   = 8'(w_beats - 32'd1);
    axi_ssr_req_o.ar.size  = axi_size(DataWidth / 8);
    axi_ssr_req_o.ar.burst = BurstIncr;
    axi_ssr_req_o.ar.user  = r_user;
    axi_ssr_req_o.r_ready  = data_ready_i;
  end

  assign desc_ready_o = (r_state == IDLE);
  assign data_o       = DataWidth'(axi_ssr_rsp_i.r.data);
  assign data_valid_o = axi_ssr_rsp_i.r_valid;
  assign data_last_o  = axi_ssr_rsp_i.r_valid && axi_ssr_rsp_i.r.last &&
                        (r_state == DRAIN) && (r_outstanding == OutsWidth'(1));
  assign done_o       = (r_state == DRAIN) && (r_outstanding == '0);
  assign err_o        = r_err;

  assign w_unused = ^{axi_ssr_rsp_i.aw_ready, axi_ssr_rsp_i.w_ready, axi_ssr_rsp_i.b_valid,
                      axi_ssr_rsp_i.b, axi_ssr_rsp_i.r.id, axi_ssr_rsp_i.r.resp[0],
                      axi_ssr_rsp_i.r.user};

endmodule

// File: tb/tb_axi_pack_ssr_read_issuer.sv
// Randomized scoreboard bench for axi_pack_ssr_read_issuer with an element-level reference model.
module tb_axi_pack_ssr_read_issuer;
  import axi_pack_pkg::*;

  localparam int unsigned MBL  = 4;
  localparam int unsigned NOUT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_addr = '0;
  logic [31:0] desc_num = '0;
  logic [31:0] desc_stride = '0;
  ssr_user_t   desc_user = '0;
  ssr_req_t    req;
  ssr_rsp_t    rsp;
  logic [31:0] data;
  logic        data_valid;
  logic        data_ready = 1'b0;
  logic        data_last;
  logic        done;
  logic        err;

  axi_pack_ssr_read_issuer #(
    .AddrWidth(32), .DataWidth(32), .AxiIdWidth(2),
    .MaxBurstLen(MBL), .NumOutstandingRead(NOUT),
    .axi_ssr_req_t(ssr_req_t), .axi_ssr_rsp_t(ssr_rsp_t)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .desc_valid_i(desc_valid), .desc_ready_o(desc_ready),
    .desc_addr_i(desc_addr), .desc_num_i(desc_num), .desc_stride_i(desc_stride),
    .desc_user_i(desc_user),
    .axi_ssr_req_o(req), .axi_ssr_rsp_i(rsp),
    .data_o(data), .data_valid_o(data_valid), .data_ready_i(data_ready),
    .data_last_o(data_last), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; ssr_user_t user; } exp_ar_t;
  typedef struct { logic [31:0] data; logic last; } exp_el_t;
  typedef struct { logic [31:0] addr; logic [7:0] len; } burst_t;

  exp_ar_t exp_ar_q[$];
  exp_el_t exp_el_q[$];
  logic    exp_done_q[$];
  burst_t  sl_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int b_outs   = 0;
  int n_ar     = 0;
  int sl_beat  = 0;
  int stall    = 0;
  bit hold_r   = 1'b0;
  bit last_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // Memory contents seen by the slave: a hash of burst address and beat index.
  function automatic logic [31:0] elem_data(input logic [31:0] baddr, input int unsigned k);
    return (baddr * 32'h9E3779B1) ^ (32'(k) * 32'h85EBCA6B) ^ 32'h5A5A1234;
  endfunction

  function automatic bit elem_err(input logic [31:0] d);
    return d[3:0] == 4'h0;
  endfunction

  // Reference model: element i lives in burst i/MBL at base + (i/MBL)*MBL*stride.
  task automatic model_desc(input logic [31:0] addr, input int unsigned num,
                            input logic [31:0] stride, input ssr_user_t user, output bit e);
    int unsigned b, k, rem;
    logic [31:0] ba, d;
    e = 1'b0;
    for (int unsigned i = 0; i < num; i++) begin
      b  = i / MBL;
      k  = i % MBL;
      ba = addr + (32'(b) * 32'(MBL)) * stride;
      d  = elem_data(ba, k);
      exp_el_q.push_back('{d, (i == num - 1)});
      e |= elem_err(d);
      if (k == 0) begin
        rem = num - i;
        exp_ar_q.push_back('{ba, 8'(((rem > MBL) ? MBL : rem) - 1), user});
      end
    end
    exp_done_q.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (1) begin
      @(negedge clk);
      if (desc_ready) break;
      if (++t > 3000) begin chk("idle_timeout", 0, 1); break; end
    end
  endtask

  task automatic run_desc(input logic [31:0] addr, input int unsigned num,
                          input logic [31:0] stride, input ssr_user_t user);
    bit e;
    int t = 0;
    model_desc(addr, num, stride, user, e);
    @(posedge clk); #1;
    desc_addr = addr; desc_num = num; desc_stride = stride; desc_user = user;
    desc_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (desc_ready) break;
      if (++t > 3000) begin
        chk("desc_ready_timeout", 0, 1);
        desc_valid = 1'b0;
        return;
      end
    end
    chk("err_held_until_accept", err, last_err);
    @(posedge clk); #1;
    desc_valid = 1'b0;
    @(negedge clk);
    chk("err_clear_on_accept", err, 0);
    chk("desc_ready_busy", desc_ready, 0);
    if (num == 0) begin
      chk("zero_done_next_cycle", done, 1);
      chk("zero_no_ar", req.ar_valid, 0);
      @(negedge clk);
      chk("zero_done_single_pulse", done, 0);
    end
    last_err = e;
  endtask

  // AXI slave: accepts ARs at random, returns in-order beats with random gaps.
  initial begin
    bit arhs, rhs;
    logic [31:0] d;
    rsp = '0;
    forever begin
      @(negedge clk);
      arhs = req.ar_valid && rsp.ar_ready && !rst;
      rhs  = rsp.r_valid && req.r_ready && !rst;
      if (arhs) sl_q.push_back('{req.ar.addr, req.ar.len});
      if (rhs) begin
        if (rsp.r.last) begin
          if (sl_q.size() > 0) void'(sl_q.pop_front());
          sl_beat = 0;
        end else begin
          sl_beat++;
        end
      end
      @(posedge clk); #1;
      rsp.ar_ready = ($urandom_range(0, 3) != 0);
      if (!rsp.r_valid || rhs) begin
        if (!hold_r && sl_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          d = elem_data(sl_q[0].addr, sl_beat);
          rsp.r_valid = 1'b1;
          rsp.r.data  = d;
          rsp.r.last  = (sl_beat == int'(sl_q[0].len));
          rsp.r.resp  = elem_err(d) ? RespSlvErr : RespOkay;
          rsp.r.id    = '0;
        end else begin
          rsp.r_valid = 1'b0;
        end
      end
    end
  end

  // Element consumer with random backpressure and forced stalls.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall > 0) begin
        data_ready = 1'b0;
        stall--;
      end else begin
        data_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a transfer.
  initial begin
    exp_ar_t ea;
    exp_el_t ee;
    logic    ed;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req.ar_valid && rsp.ar_ready) begin
          chk("ar_outstanding_limit", (b_outs < NOUT), 1);
          b_outs++;
          n_ar++;
          if (exp_ar_q.size() == 0) begin
            chk("ar_unexpected", 1, 0);
          end else begin
            ea = exp_ar_q.pop_front();
            chk("ar_addr", req.ar.addr, ea.addr);
            chk("ar_len", req.ar.len, ea.len);
            chk("ar_user", req.ar.user, ea.user);
            chk("ar_size_burst_id", {req.ar.size, req.ar.burst, req.ar.id}, {3'd2, 2'b01, 2'b00});
          end
        end
        if (data_valid && data_ready) begin
          if (rsp.r.last && b_outs > 0) b_outs--;
          if (exp_el_q.size() == 0) begin
            chk("data_unexpected", 1, 0);
          end else begin
            ee = exp_el_q.pop_front();
            chk("data_value", data, ee.data);
            chk("data_last", data_last, ee.last);
          end
        end
        if (done) begin
          if (exp_done_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            ed = exp_done_q.pop_front();
            chk("err_at_done", err, ed);
            chk("write_chan_idle", {req.aw_valid, req.w_valid, req.b_ready}, 3'b001);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Stimulus sequence.
  initial begin
    int base_ar, t;
    repeat (3) @(negedge clk);
    chk("reset_desc_ready", desc_ready, 1);
    chk("reset_ar_valid", req.ar_valid, 0);
    chk("reset_done_err", {done, err}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed 10-element descriptor at 0x100, stride 4.
    run_desc(32'h100, 10, 32'd4, 5'b1_0011);
    // Zero-length descriptor.
    run_desc(32'h2000, 0, 32'd8, 5'b0_0001);

    // R withheld: only NOUT bursts may be in flight.
    wait_idle();
    hold_r = 1'b1;
    base_ar = n_ar;
    run_desc(32'h4000, 12, 32'd16, 5'b0_1010);
    repeat (20) @(negedge clk);
    chk("ar_count_while_r_held", n_ar - base_ar, NOUT);
    chk("third_ar_blocked", req.ar_valid, 0);
    hold_r = 1'b0;

    // Consumer stall mid-stream.
    run_desc(32'h8000, 16, 32'd12, 5'b1_1111);
    t = 0;
    while (!data_valid && t < 200) begin @(negedge clk); t++; end
    stall = 5;
    @(posedge clk); #2;
    chk("stall_r_ready_low", req.r_ready, 0);

    // Randomized descriptors.
    for (int n = 0; n < 25; n++) begin
      run_desc($urandom, $urandom_range(0, 18),
               ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64)),
               5'($urandom));
    end

    // Reset while stuck in ISSUE with R withheld.
    wait_idle();
    hold_r = 1'b1;
    run_desc(32'hC000, 20, 32'd4, 5'b0_0110);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ar_valid", req.ar_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_data_last", data_last, 0);
    exp_ar_q.delete();
    exp_el_q.delete();
    exp_done_q.delete();
    sl_q.delete();
    sl_beat = 0;
    b_outs = 0;
    rsp.r_valid = 1'b0;
    last_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_r = 1'b0;
    @(negedge clk);
    chk("desc_ready_after_rst", desc_ready, 1);
    run_desc(32'h100, 10, 32'd4, 5'b1_0000);

    wait_idle();
    repeat (10) @(negedge clk);
    chk("ar_queue_empty", exp_ar_q.size(), 0);
    chk("elem_queue_empty", exp_el_q.size(), 0);
    chk("done_queue_empty", exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
